// File: rtl/ripple_tap_sequencer.sv
// Synchronizes one divider tap into clk, turns its rising edges into ticks, and steps an LED pattern.
// Latency tap_in rise -> led change: SYNC_STAGES+2 edges; no backpressure, the tap is sampled every cycle.
module ripple_tap_sequencer #(
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tap_in,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic                 tick,
  output logic [LED_WIDTH-1:0] led,
  output logic                 dir
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic [LED_WIDTH-1:0] LED_ONE     = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_TWO     = LED_WIDTH'(2);
  localparam logic [LED_WIDTH-1:0] LED_MSB     = LED_ONE << (LED_WIDTH - 1);
  localparam logic [LED_WIDTH-1:0] LED_MSB_LO1 = LED_ONE << (LED_WIDTH - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   prev_q;
  logic [2:0]             arm_cnt;
  logic                   armed;
  mode_t                  mode_q;
  mode_t                  mode_in;
  logic                   mode_change;
  logic                   led_onehot;

  assign sync_lvl    = sync_q[SYNC_STAGES-1];
  assign mode_in     = mode_t'(mode);
  assign mode_change = (mode_in != mode_q);
  assign led_onehot  = (led != '0) && ((led & (led - LED_ONE)) == '0);

  // The arm window covers the synchronizer fill so a tap already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      tick    <= 1'b0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tap_in};
      prev_q <= sync_lvl;
      tick   <= armed & sync_lvl & ~prev_q;
      if (!armed) begin
        if (arm_cnt == 3'(SYNC_STAGES)) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_COUNT;
      led    <= '0;
      dir    <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (mode_change) begin
        case (mode_in)
          MODE_COUNT: led <= '0;
          MODE_SHIFT: led <= LED_ONE;
          MODE_BOUNCE: begin
            led <= LED_ONE;
            dir <= 1'b0;
          end
          MODE_HOLD: ;
        endcase
      end else if (tick && enable) begin
        case (mode_q)
          MODE_COUNT: led <= led + LED_ONE;
          MODE_SHIFT: begin
            if (!led_onehot) begin
              led <= LED_ONE;
              dir <= 1'b0;
            end else begin
              led <= {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
            end
          end
          MODE_BOUNCE: begin
            // Direction flips on the step that leaves an end position, so each end is shown once.
            if (!led_onehot) begin
              led <= LED_ONE;
              dir <= 1'b0;
            end else if (!dir) begin
              if (led == LED_MSB) begin
                led <= LED_MSB_LO1;
                dir <= 1'b1;
              end else begin
                led <= led << 1;
              end
            end else begin
              if (led == LED_ONE) begin
                led <= LED_TWO;
                dir <= 1'b0;
              end else begin
                led <= led >> 1;
              end
            end
          end
          MODE_HOLD: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ripple_tap_sequencer.sv
// Directed bench for ripple_tap_sequencer: table of per-tap-period vectors plus hand sequences.
module tb_ripple_tap_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tap_in;
  logic       enable;
  logic [1:0] mode;
  logic       tick;
  logic [7:0] led;
  logic       dir;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ripple_tap_sequencer #(.SYNC_STAGES(2), .LED_WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .tap_in (tap_in),
    .enable (enable),
    .mode   (mode),
    .tick   (tick),
    .led    (led),
    .dir    (dir)
  );

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [7:0] led;
    logic       dir;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [1:0] m, input logic e, input logic [7:0] l, input logic d);
    vecs[n_vec].mode = m;
    vecs[n_vec].en   = e;
    vecs[n_vec].led  = l;
    vecs[n_vec].dir  = d;
    n_vec++;
  endtask

  // One clk_div8-style tap period: 8 cycles high, 8 low. Index i is the edge k+i after the rise.
  task automatic tap_period(output int n_ticks, output int pos, output logic [7:0] led_at_tick);
    n_ticks     = 0;
    pos         = -1;
    led_at_tick = 8'hxx;
    tap_in      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tick) begin
        n_ticks++;
        if (pos < 0) begin
          pos         = i;
          led_at_tick = led;
        end
      end
      if (i == 7) tap_in = 1'b0;
    end
  endtask

  initial begin
    int         nt;
    int         ps;
    logic [7:0] lt;
    logic [7:0] bounce_led [20];
    logic       bounce_dir [20];
    logic [7:0] shift_led  [8];

    bounce_led = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                   8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    bounce_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    shift_led  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    // First BOUNCE row seeds 01 then steps; first SHIFT row seeds 01 then rotates.
    for (int i = 0; i < 20; i++) add_vec(2'b10, 1'b1, bounce_led[i], bounce_dir[i]);
    for (int i = 0; i < 8; i++)  add_vec(2'b01, 1'b1, shift_led[i], 1'b0);
    for (int i = 0; i < 5; i++)  add_vec(2'b01, 1'b0, 8'h01, 1'b0);
    add_vec(2'b01, 1'b1, 8'h02, 1'b0);
    add_vec(2'b01, 1'b1, 8'h04, 1'b0);
    add_vec(2'b01, 1'b1, 8'h08, 1'b0);
    for (int i = 0; i < 10; i++) add_vec(2'b11, 1'b1, 8'h08, 1'b0);

    reset  = 1'b1;
    tap_in = 1'b1;
    enable = 1'b1;
    mode   = 2'b00;
    for (int i = 0; i < 3; i++) step();
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_dir", 32'(dir), 32'h0);

    // Tap held high across release must not produce a tick.
    reset = 1'b0;
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick) nt++;
    end
    chk("arm_no_tick", 32'(nt), 32'h0);
    chk("arm_led", 32'(led), 32'h00);
    tap_in = 1'b0;
    for (int i = 0; i < 8; i++) step();

    for (int i = 0; i < 256; i++) begin
      tap_period(nt, ps, lt);
      chk("cnt_ticks", 32'(nt), 32'h1);
      chk("cnt_tick_pos", 32'(ps), 32'h2);
      chk("cnt_led_at_tick", 32'(lt), 32'(i % 256));
      chk("cnt_led", 32'(led), 32'((i + 1) % 256));
    end
    chk("cnt_wrap", 32'(led), 32'h00);

    for (int v = 0; v < n_vec; v++) begin
      mode   = vecs[v].mode;
      enable = vecs[v].en;
      tap_period(nt, ps, lt);
      chk("vec_ticks", 32'(nt), 32'h1);
      chk("vec_tick_pos", 32'(ps), 32'h2);
      chk("vec_led", 32'(led), 32'(vecs[v].led));
      chk("vec_dir", 32'(dir), 32'(vecs[v].dir));
    end

    // COUNT -> SHIFT on the edge that consumes a tick: seed wins.
    mode   = 2'b00;
    enable = 1'b1;
    step();
    step();
    chk("count_seed", 32'(led), 32'h00);
    tap_period(nt, ps, lt);
    tap_period(nt, ps, lt);
    chk("count_pre_switch", 32'(led), 32'h02);
    tap_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 2) begin
        chk("sw_tick", 32'(tick), 32'h1);
        mode = 2'b01;
      end
      if (i == 3) chk("sw_seed", 32'(led), 32'h01);
      if (i == 5) chk("sw_after", 32'(led), 32'h01);
      if (i == 7) tap_in = 1'b0;
    end

    // Reset mid-BOUNCE at led=20, dir=1.
    mode = 2'b10;
    step();
    step();
    chk("bnc_seed", 32'(led), 32'h01);
    for (int i = 0; i < 9; i++) tap_period(nt, ps, lt);
    chk("bnc_pre_rst_led", 32'(led), 32'h20);
    chk("bnc_pre_rst_dir", 32'(dir), 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_led", 32'(led), 32'h00);
    chk("mid_rst_dir", 32'(dir), 32'h0);
    chk("mid_rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    step();
    chk("post_rst_seed", 32'(led), 32'h01);
    chk("post_rst_dir", 32'(dir), 32'h0);
    tap_period(nt, ps, lt);
    chk("post_rst_ticks", 32'(nt), 32'h1);
    chk("post_rst_led", 32'(led), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
